// File: rtl/id_ex_reg.sv
// id_ex_reg: pipeline register between the decode (id) and execute (ex) stages.
//
// Captures the decoded operands, the instruction, its address and the
// writeback control on every rising clock edge.  A NOP bubble is loaded
// instead when:
//   - a taken jump arrives (and for FLUSH_CYCLES-1 further cycles after it),
//   - a hold request of level ID or higher arrives (hold_flag_i >= 3),
//   - a load-use hazard is detected between the load sitting in ex and the
//     instruction presented by id; stall_o then freezes pc_reg and if_id for
//     that cycle so the same instruction is re-presented on the next one.
//
// Parameters:
//   FLUSH_CYCLES  bubbles injected per taken jump, 1..7
//   NOP_INST      encoding driven on inst_o for a bubble (addi x0,x0,0)
//
// Ports:
//   clk                        clock, rising edge
//   rst                        synchronous reset, active low
//   inst_i, inst_addr_i        instruction and its address from id
//   op1_i, op2_i               ALU operands from id
//   op1_jump_i, op2_jump_i     jump-target operands from id
//   reg1_rdata_i, reg2_rdata_i register file read data
//   reg1_raddr_i, reg2_raddr_i source register indices of the id instruction
//   reg_we_i, reg_waddr_i      writeback enable / index
//   jump_flag_i                taken jump from ex
//   hold_flag_i                hold request: 0=NONE 1=PC 2=IF 3=ID
//   *_o                        registered copies of the above, to ex
//   valid_o                    ex holds a real (non-bubble) instruction
//   stall_o                    combinational load-use stall to pc_reg/if_id

module id_ex_reg #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter logic [31:0] NOP_INST     = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   input  logic [31:0] op1_jump_i,
   input  logic [31:0] op2_jump_i,
   input  logic [31:0] reg1_rdata_i,
   input  logic [31:0] reg2_rdata_i,
   input  logic [4:0]  reg1_raddr_i,
   input  logic [4:0]  reg2_raddr_i,
   input  logic        reg_we_i,
   input  logic [4:0]  reg_waddr_i,
   input  logic        jump_flag_i,
   input  logic [2:0]  hold_flag_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic [31:0] op1_o,
   output logic [31:0] op2_o,
   output logic [31:0] op1_jump_o,
   output logic [31:0] op2_jump_o,
   output logic [31:0] reg1_rdata_o,
   output logic [31:0] reg2_rdata_o,
   output logic        reg_we_o,
   output logic [4:0]  reg_waddr_o,
   output logic        valid_o,
   output logic        stall_o
);

   localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [2:0] HOLD_ID      = 3'd3;

   logic [2:0] flush_cnt;
   logic       flush_now;
   logic       hazard;
   logic       bubble;

   always_comb begin
      flush_now = jump_flag_i || (hold_flag_i >= HOLD_ID) || (flush_cnt != '0);

      // A load in ex whose destination is read by the instruction in id.
      hazard = valid_o
            && (inst_o[6:0] == OPCODE_LOAD)
            && reg_we_o
            && (reg_waddr_o != '0)
            && ((reg_waddr_o == reg1_raddr_i) || (reg_waddr_o == reg2_raddr_i));

      // A flush already discards the id instruction, so no stall is needed.
      stall_o = hazard && !flush_now;
      bubble  = flush_now || hazard;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         inst_o       <= NOP_INST;
         inst_addr_o  <= '0;
         op1_o        <= '0;
         op2_o        <= '0;
         op1_jump_o   <= '0;
         op2_jump_o   <= '0;
         reg1_rdata_o <= '0;
         reg2_rdata_o <= '0;
         reg_we_o     <= 1'b0;
         reg_waddr_o  <= '0;
         valid_o      <= 1'b0;
         flush_cnt    <= '0;
      end else begin
         // The address is carried through bubbles as well as real captures.
         inst_addr_o <= inst_addr_i;
         if (bubble) begin
            inst_o       <= NOP_INST;
            op1_o        <= '0;
            op2_o        <= '0;
            op1_jump_o   <= '0;
            op2_jump_o   <= '0;
            reg1_rdata_o <= '0;
            reg2_rdata_o <= '0;
            reg_we_o     <= 1'b0;
            reg_waddr_o  <= '0;
            valid_o      <= 1'b0;
         end else begin
            inst_o       <= inst_i;
            op1_o        <= op1_i;
            op2_o        <= op2_i;
            op1_jump_o   <= op1_jump_i;
            op2_jump_o   <= op2_jump_i;
            reg1_rdata_o <= reg1_rdata_i;
            reg2_rdata_o <= reg2_rdata_i;
            reg_we_o     <= reg_we_i;
            reg_waddr_o  <= reg_waddr_i;
            valid_o      <= 1'b1;
         end
         // A nonzero count implies flush_now, so decrementing outside the
         // flush branch is equivalent; a jump always restarts the count.
         if (jump_flag_i) begin
            flush_cnt <= FLUSH_RELOAD;
         end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: bench for id_ex_reg.  Three instances (FLUSH_CYCLES = 1, 2
// and 4) share one set of inputs; each is compared against a behavioural
// model of the stage register after every edge, and stall_o is compared
// before every edge.  Directed steps cover the listed scenarios, followed by
// a randomized phase.

module tb_id_ex_reg;

   localparam int N = 3;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i, inst_addr_i, op1_i, op2_i, op1_jump_i, op2_jump_i;
   logic [31:0] reg1_rdata_i, reg2_rdata_i;
   logic [4:0]  reg1_raddr_i, reg2_raddr_i, reg_waddr_i;
   logic        reg_we_i, jump_flag_i;
   logic [2:0]  hold_flag_i;

   logic [31:0] inst_o [N];
   logic [31:0] inst_addr_o [N];
   logic [31:0] op1_o [N];
   logic [31:0] op2_o [N];
   logic [31:0] op1_jump_o [N];
   logic [31:0] op2_jump_o [N];
   logic [31:0] reg1_rdata_o [N];
   logic [31:0] reg2_rdata_o [N];
   logic        reg_we_o [N];
   logic [4:0]  reg_waddr_o [N];
   logic        valid_o [N];
   logic        stall_o [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : gen_dut
      id_ex_reg #(
         .FLUSH_CYCLES((g == 0) ? 1 : (g == 1) ? 2 : 4),
         .NOP_INST(NOP)
      ) dut (
         .clk(clk), .rst(rst),
         .inst_i(inst_i), .inst_addr_i(inst_addr_i),
         .op1_i(op1_i), .op2_i(op2_i),
         .op1_jump_i(op1_jump_i), .op2_jump_i(op2_jump_i),
         .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
         .reg1_raddr_i(reg1_raddr_i), .reg2_raddr_i(reg2_raddr_i),
         .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
         .jump_flag_i(jump_flag_i), .hold_flag_i(hold_flag_i),
         .inst_o(inst_o[g]), .inst_addr_o(inst_addr_o[g]),
         .op1_o(op1_o[g]), .op2_o(op2_o[g]),
         .op1_jump_o(op1_jump_o[g]), .op2_jump_o(op2_jump_o[g]),
         .reg1_rdata_o(reg1_rdata_o[g]), .reg2_rdata_o(reg2_rdata_o[g]),
         .reg_we_o(reg_we_o[g]), .reg_waddr_o(reg_waddr_o[g]),
         .valid_o(valid_o[g]), .stall_o(stall_o[g])
      );
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] inst, addr, op1, op2, j1, j2, r1, r2;
      logic        we;
      logic [4:0]  waddr;
      logic        valid;
      int          owed;   // bubbles still owed after the current one
   } mstate_t;

   mstate_t m [N];

   function automatic int fc_of(int g);
      return (g == 0) ? 1 : (g == 1) ? 2 : 4;
   endfunction

   function automatic bit m_flush(mstate_t s);
      return jump_flag_i || (int'(hold_flag_i) >= 3) || (s.owed > 0);
   endfunction

   function automatic bit m_hazard(mstate_t s);
      bit is_load = (s.inst % 128) == 3;   // opcode LOAD
      return s.valid && is_load && s.we && (s.waddr != 0)
             && (s.waddr == reg1_raddr_i || s.waddr == reg2_raddr_i);
   endfunction

   function automatic mstate_t m_step(mstate_t s, int fc);
      mstate_t n = s;
      if (!rst) begin
         n = '{inst: NOP, addr: 0, op1: 0, op2: 0, j1: 0, j2: 0, r1: 0, r2: 0,
               we: 0, waddr: 0, valid: 0, owed: 0};
         return n;
      end
      if (m_flush(s) || m_hazard(s)) begin
         n = '{inst: NOP, addr: inst_addr_i, op1: 0, op2: 0, j1: 0, j2: 0,
               r1: 0, r2: 0, we: 0, waddr: 0, valid: 0, owed: s.owed};
      end else begin
         n = '{inst: inst_i, addr: inst_addr_i, op1: op1_i, op2: op2_i,
               j1: op1_jump_i, j2: op2_jump_i, r1: reg1_rdata_i,
               r2: reg2_rdata_i, we: reg_we_i, waddr: reg_waddr_i, valid: 1,
               owed: s.owed};
      end
      if (jump_flag_i) n.owed = fc - 1;
      else if (s.owed > 0) n.owed = s.owed - 1;
      return n;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cmp_all();
      for (int g = 0; g < N; g++) begin
         chk($sformatf("inst_o[%0d]", g), inst_o[g], m[g].inst);
         chk($sformatf("inst_addr_o[%0d]", g), inst_addr_o[g], m[g].addr);
         chk($sformatf("op1_o[%0d]", g), op1_o[g], m[g].op1);
         chk($sformatf("op2_o[%0d]", g), op2_o[g], m[g].op2);
         chk($sformatf("op1_jump_o[%0d]", g), op1_jump_o[g], m[g].j1);
         chk($sformatf("op2_jump_o[%0d]", g), op2_jump_o[g], m[g].j2);
         chk($sformatf("reg1_rdata_o[%0d]", g), reg1_rdata_o[g], m[g].r1);
         chk($sformatf("reg2_rdata_o[%0d]", g), reg2_rdata_o[g], m[g].r2);
         chk($sformatf("reg_we_o[%0d]", g), 32'(reg_we_o[g]), 32'(m[g].we));
         chk($sformatf("reg_waddr_o[%0d]", g), 32'(reg_waddr_o[g]), 32'(m[g].waddr));
         chk($sformatf("valid_o[%0d]", g), 32'(valid_o[g]), 32'(m[g].valid));
      end
   endtask

   // One clock: check stall before the edge, advance model, check outputs after.
   task automatic cycle();
      @(negedge clk);
      for (int g = 0; g < N; g++)
         chk($sformatf("stall_o[%0d]", g), 32'(stall_o[g]),
             32'(m_hazard(m[g]) && !m_flush(m[g])));
      @(posedge clk);
      for (int g = 0; g < N; g++) m[g] = m_step(m[g], fc_of(g));
      #1;
      cmp_all();
   endtask

   // Random data with an R-type opcode, so it never creates a hazard later.
   task automatic benign();
      inst_i       = ($urandom() & 32'hFFFF_FF80) | 32'h33;
      inst_addr_i  = $urandom();
      op1_i        = $urandom();
      op2_i        = $urandom();
      op1_jump_i   = $urandom();
      op2_jump_i   = $urandom();
      reg1_rdata_i = $urandom();
      reg2_rdata_i = $urandom();
      reg1_raddr_i = 5'($urandom());
      reg2_raddr_i = 5'($urandom());
      reg_we_i     = 1'($urandom());
      reg_waddr_i  = 5'($urandom());
      jump_flag_i  = 1'b0;
      hold_flag_i  = 3'd0;
   endtask

   task automatic present_lw(logic [4:0] rd);
      benign();
      inst_i      = (rd == 0) ? 32'h00012003 : 32'h00012283;
      reg_we_i    = 1'b1;
      reg_waddr_i = rd;
   endtask

   task automatic present_add_x6_x5_x1(logic [4:0] rs1);
      benign();
      inst_i       = 32'h00128333;
      reg1_raddr_i = rs1;
      reg2_raddr_i = 5'd1;
      reg_we_i     = 1'b1;
      reg_waddr_i  = 5'd6;
   endtask

   initial begin
      logic [31:0] saved;
      for (int g = 0; g < N; g++)
         m[g] = '{inst: 'x, addr: 'x, op1: 'x, op2: 'x, j1: 'x, j2: 'x,
                  r1: 'x, r2: 'x, we: 'x, waddr: 'x, valid: 'x, owed: 0};

      // Reset with random inputs (incl. a jump, which reset must override).
      rst = 1'b0;
      benign();
      jump_flag_i = 1'b1;
      m[0].valid = 1'b0;  // outputs unknown before the first edge; skip stall check
      @(posedge clk);
      for (int g = 0; g < N; g++) m[g] = m_step(m[g], fc_of(g));
      #1;
      cmp_all();
      benign();
      cycle();
      for (int g = 0; g < N; g++) begin
         chk("reset inst_o", inst_o[g], 32'h00000013);
         chk("reset reg_we_o", 32'(reg_we_o[g]), 0);
         chk("reset valid_o", 32'(valid_o[g]), 0);
         chk("reset stall_o", 32'(stall_o[g]), 0);
      end

      // addi x1,x0,5
      rst = 1'b1;
      benign();
      inst_i = 32'h00500093; op1_i = 0; op2_i = 5;
      reg_we_i = 1'b1; reg_waddr_i = 5'd1; reg1_raddr_i = 0; reg2_raddr_i = 5'd5;
      cycle();
      chk("addi inst_o", inst_o[1], 32'h00500093);
      chk("addi op2_o", op2_o[1], 5);
      chk("addi reg_we_o", 32'(reg_we_o[1]), 1);
      chk("addi reg_waddr_o", 32'(reg_waddr_o[1]), 1);
      chk("addi valid_o", 32'(valid_o[1]), 1);

      // Jump flush: FLUSH_CYCLES=2 gives two bubbles, then a capture.
      benign(); jump_flag_i = 1'b1;
      cycle();
      chk("jump edge1 inst_o", inst_o[1], NOP);
      chk("jump edge1 reg_we_o", 32'(reg_we_o[1]), 0);
      chk("jump fc1 edge1 valid_o", 32'(valid_o[0]), 0);
      benign();
      cycle();
      chk("jump edge2 inst_o", inst_o[1], NOP);
      chk("jump edge2 reg_we_o", 32'(reg_we_o[1]), 0);
      chk("jump fc1 edge2 valid_o", 32'(valid_o[0]), 1);
      benign(); saved = inst_i;
      cycle();
      chk("jump edge3 inst_o", inst_o[1], saved);
      chk("jump edge3 valid_o", 32'(valid_o[1]), 1);
      for (int i = 0; i < 3; i++) begin benign(); cycle(); end

      // Hold ID for 3 cycles, then hold IF (ignored).
      for (int i = 0; i < 3; i++) begin
         benign(); hold_flag_i = 3'd3;
         cycle();
         chk("hold3 valid_o", 32'(valid_o[0]), 0);
         chk("hold3 inst_o", inst_o[0], NOP);
      end
      benign(); hold_flag_i = 3'd2; saved = inst_i;
      cycle();
      chk("hold2 valid_o", 32'(valid_o[0]), 1);
      chk("hold2 inst_o", inst_o[0], saved);

      // Load-use: lw x5 in ex, add x6,x5,x1 in id.
      present_lw(5'd5);
      cycle();
      present_add_x6_x5_x1(5'd5);
      #1;
      chk("lu stall_o on", 32'(stall_o[0]), 1);
      cycle();
      chk("lu bubble valid_o", 32'(valid_o[0]), 0);
      chk("lu bubble inst_o", inst_o[0], NOP);
      #1;
      chk("lu stall_o off", 32'(stall_o[0]), 0);
      cycle();
      chk("lu capture inst_o", inst_o[0], 32'h00128333);
      chk("lu capture valid_o", 32'(valid_o[0]), 1);

      // Same with rd=x0: no stall.
      present_lw(5'd0);
      cycle();
      present_add_x6_x5_x1(5'd0);
      #1;
      chk("lu x0 stall_o", 32'(stall_o[0]), 0);
      cycle();
      chk("lu x0 valid_o", 32'(valid_o[0]), 1);

      // Hazard and jump together: no stall, bubble, counter loaded.
      present_lw(5'd5);
      cycle();
      present_add_x6_x5_x1(5'd5); jump_flag_i = 1'b1;
      #1;
      chk("hz+jump stall_o", 32'(stall_o[1]), 0);
      cycle();
      chk("hz+jump inst_o", inst_o[1], NOP);
      benign();
      cycle();
      chk("hz+jump counter valid_o", 32'(valid_o[1]), 0);
      for (int i = 0; i < 3; i++) begin benign(); cycle(); end

      // Reset while FLUSH_CYCLES=4 counter is nonzero.
      benign(); jump_flag_i = 1'b1;
      cycle();
      benign(); rst = 1'b0;
      cycle();
      rst = 1'b1; benign(); saved = inst_i;
      cycle();
      chk("midrst inst_o", inst_o[2], saved);
      chk("midrst valid_o", 32'(valid_o[2]), 1);

      // Randomized phase.
      for (int i = 0; i < 400; i++) begin
         benign();
         if ($urandom_range(0, 2) == 0) inst_i = ($urandom() & 32'hFFFF_FF80) | 32'h03;
         if ($urandom_range(0, 1) == 0) reg1_raddr_i = m[0].waddr;
         if ($urandom_range(0, 3) == 0) reg2_raddr_i = m[1].waddr;
         jump_flag_i = ($urandom_range(0, 9) == 0);
         hold_flag_i = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                   : 3'($urandom_range(0, 2));
         rst = ($urandom_range(0, 39) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
